ifu_0: RTL and testbench
========================

Name: ifu_0

Overview:
- Instruction fetch unit for the simpleRV32IM core. Sits directly upstream of the decode stage.
- Owns the PC and issues word reads to the instruction SRAM, which has a fixed 1-cycle read latency.
- Buffers returned words in a small FIFO and presents {inst, inst_addr} to decode.
- Honours decode's hold (replay) and EX's jump (flush and redirect) semantics.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- DEPTH, 2: instruction FIFO entries (power of two, ≥2).
- NOP_INST, 32'h0000_0013: value driven on inst_o when the FIFO is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- jump_flag_i  in  1  redirect request from EX.
- jump_addr_i  in  32  redirect target; bits [1:0] ignored (forced 0).
- hold_flag_i  in  1  decode stall: the presented instruction is not consumed this cycle.
- isram_req_o  out  1  read request.
- isram_addr_o  out  32  word-aligned read address (= PC).
- isram_ready_i  in  1  SRAM accepts the request this cycle.
- isram_rdata_i  in  32  read data, valid exactly 1 cycle after acceptance.
- inst_o  out  32  FIFO head instruction, or NOP_INST when empty.
- inst_addr_o  out  32  FIFO head address, or 0 when empty.
- inst_valid_o  out  1  FIFO non-empty.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, FIFO count=0, pending=0.
  - Outputs while rst is high: isram_req_o=0, inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0.
- Accept: acc = isram_req_o & isram_ready_i.
  - On acc: pc += 4 (modulo 2^32, wraps FFFF_FFFC→0000_0000); pending <= 1. Otherwise pending <= 0.
- Response: when pending=1 and no flush this cycle, isram_rdata_i is pushed with its address (captured at request) at the posedge.
  - Push into a full FIFO cannot occur (guaranteed by the issue rule); an assertion checks this.
- Pop: pop = inst_valid_o & ~hold_flag_i & ~jump_flag_i.
  - The head leaves at the posedge.
  - In a hold cycle the head is re-presented next cycle unchanged (replay).
- Issue rule: isram_req_o = ~rst & ~jump_flag_i & (count + pending − pop < DEPTH). This sustains 1 instruction/cycle with DEPTH=2.
- Request stability: isram_addr_o = pc always. While req=1 and ready=0, pc is unchanged, so the address is held stable.
- Flush (jump_flag_i=1, cycle J):
  - FIFO count <= 0; any response in cycle J is dropped; pending <= 0; pc <= {jump_addr_i[31:2],2'b00}; req=0 in J.
  - J+1: request to target. J+2: data pushed. J+3: inst_valid_o=1, inst_addr_o=target.
- Simultaneous events:
  - jump and hold together: jump wins, full flush.
  - push and pop together: count unchanged; the head advances to the next entry.
  - rst overrides everything; a response due in the first cycle after rst falls is dropped, because pending was cleared by rst.
- Latency from reset release (cycle 0 = first cycle with rst=0):
  - req in cycle 0 to RESET_PC; push at end of cycle 1; inst_valid_o=1 in cycle 2.
- FIFO: circular buffer with wr/rd pointers and a count; pointers wrap mod DEPTH.
  - inst_o/inst_addr_o are read from the head register, so no combinational path from isram_rdata_i to outputs.

Test Plan:
- Reset release, ready=1, SRAM word at addr A = 0xA0000000+A, no hold/jump:
  - req addresses 0,4,8,… each cycle; inst_valid_o rises in cycle 2.
  - inst_addr_o = 0,4,8,… on consecutive cycles with matching data.
- Hold high for cycles 5–7 while streaming:
  - inst_addr_o frozen at its cycle-5 value through cycle 7, then resumes +4 per cycle.
  - No address skipped or duplicated after release; count never exceeds 2.
- jump_flag_i=1 with jump_addr_i=0x0000_0103 in cycle 10:
  - req=0 in 10; req addr 0x100 in 11; inst_valid_o=0 in 11–12.
  - inst_addr_o=0x100 in 13; no pre-jump address appears after cycle 10.
- Jump and hold asserted together in one cycle to 0x200: behaves identically to the jump-only case (first valid 0x200 at J+3).
- isram_ready_i low for 3 cycles mid-stream: isram_addr_o stable across the stall; the sequence continues without gaps or duplicates.
- RESET_PC=0xFFFF_FFF8 streaming, then rst pulsed for 1 cycle mid-stream:
  - addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
  - After the rst pulse, output restarts from RESET_PC and the stale response is not delivered.

Source files
------------

// File: rtl/ifu_0.sv
// Instruction fetch unit: owns the PC, issues 1-cycle-latency word reads to the
// instruction SRAM and buffers returned words in a small FIFO in front of decode.
module ifu_0 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        isram_req_o,
    output logic [31:0] isram_addr_o,
    input  logic        isram_ready_i,
    input  logic [31:0] isram_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    logic [31:0]   pc_reg;
    logic          pending_reg;
    logic [31:0]   pend_addr_reg;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   addr_mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW:0]   occupancy;
    logic          valid;
    logic          acc;
    logic          push;
    logic          pop;
    logic          jump_addr_unused;

    assign jump_addr_unused = ^jump_addr_i[1:0];

    assign valid = ~rst & (count_reg != '0);
    assign pop   = valid & ~hold_flag_i & ~jump_flag_i;
    assign push  = ~rst & pending_reg & ~jump_flag_i;
    assign acc   = isram_req_o & isram_ready_i;

    // Occupancy after this cycle if nothing new is requested; a request is only
    // issued when its eventual response is guaranteed a free slot.
    assign occupancy = {1'b0, count_reg} + (CW+1)'(pending_reg) - (CW+1)'(pop);

    assign isram_req_o  = ~rst & ~jump_flag_i & (occupancy < DEPTH_W);
    assign isram_addr_o = pc_reg;

    assign inst_valid_o = valid;
    assign inst_o       = valid ? inst_mem[rd_ptr_reg] : NOP_INST;
    assign inst_addr_o  = valid ? addr_mem[rd_ptr_reg] : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            pending_reg   <= 1'b0;
            pend_addr_reg <= RESET_PC;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else if (jump_flag_i) begin
            // Flush: the in-flight response (if any) is dropped by clearing pending.
            pc_reg      <= {jump_addr_i[31:2], 2'b00};
            pending_reg <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            pending_reg <= acc;
            if (acc) begin
                pc_reg        <= pc_reg + 32'd4;
                pend_addr_reg <= pc_reg;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= isram_rdata_i;
            addr_mem[wr_ptr_reg] <= pend_addr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !pop) begin
            assert (count_reg != FULL);
        end
    end
endmodule

// File: tb/tb_ifu_0.sv
// Directed bench for ifu_0: a queue-based fetch model checked every cycle plus
// hand-computed literal expectations at key cycles.
module tb_ifu_0;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        hold_flag = 1'b0;
    logic        ready = 1'b1;
    logic [31:0] rdata = 32'hDEAD_BEEF;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        valid;

    int errors = 0;
    int checks = 0;
    int cyc    = -2;

    always #5 clk = ~clk;

    ifu_0 #(.RESET_PC(RPC), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag),
        .jump_addr_i  (jump_addr),
        .hold_flag_i  (hold_flag),
        .isram_req_o  (req),
        .isram_addr_o (addr),
        .isram_ready_i(ready),
        .isram_rdata_i(rdata),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .inst_valid_o (valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    // SRAM: data for an accepted request appears one cycle later, garbage otherwise.
    always @(posedge clk) rdata <= (req && ready) ? mem_word(addr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Model: PC, one outstanding-read flag, and a queue of fetched addresses.
    logic [31:0] m_pc = RPC;
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_addr = 32'h0;
    logic [31:0] q[$];
    bit          model_on = 1'b0;

    always @(negedge clk) begin
        bit          e_valid, e_req, m_pop, m_acc;
        logic [31:0] e_inst, e_ia;
        if (model_on) begin
            e_valid = !rst && q.size() > 0;
            e_inst  = e_valid ? mem_word(q[0]) : NOP;
            e_ia    = e_valid ? q[0] : 32'h0;
            m_pop   = e_valid && !hold_flag && !jump_flag;
            e_req   = !rst && !jump_flag && (q.size() + int'(m_pend) - int'(m_pop) < DEPTH);
            check("m_req", {31'b0, req}, {31'b0, e_req});
            check("m_addr", addr, m_pc);
            check("m_valid", {31'b0, valid}, {31'b0, e_valid});
            check("m_inst", inst, e_inst);
            check("m_inst_addr", inst_addr, e_ia);
            if (m_pop) $display("cyc=%0d deliver addr=%h inst=%h", cyc, e_ia, e_inst);
            m_acc = e_req && ready;
            if (rst) begin
                m_pc = RPC; m_pend = 1'b0; q.delete();
            end else if (jump_flag) begin
                m_pc = {jump_addr[31:2], 2'b00}; m_pend = 1'b0; q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_pend) q.push_back(m_pend_addr);
                m_pend = m_acc;
                if (m_acc) begin
                    m_pend_addr = m_pc;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic drive(input int c);
        rst       = (c == 30);
        jump_flag = (c == 10) || (c == 16) || (c == 60);
        jump_addr = (c == 10) ? 32'h0000_0103 : (c == 16) ? 32'h0000_0200 : 32'h7FFF_FFFD;
        hold_flag = (c >= 5 && c <= 7) || (c == 16) || (c >= 45 && $urandom_range(0, 2) == 0);
        ready     = !(c >= 22 && c <= 24) && !(c >= 45 && $urandom_range(0, 3) == 0);
    endtask

    task automatic literal(input int c);
        case (c)
            0: begin check("l_req0", {31'b0, req}, 32'h1); check("l_addr0", addr, 32'hFFFF_FFF8); end
            1: begin check("l_addr1", addr, 32'hFFFF_FFFC); check("l_valid1", {31'b0, valid}, 32'h0); end
            2: begin
                check("l_addr2", addr, 32'h0000_0000);
                check("l_valid2", {31'b0, valid}, 32'h1);
                check("l_ia2", inst_addr, 32'hFFFF_FFF8);
                check("l_inst2", inst, 32'h9FFF_FFF8);
            end
            3: check("l_ia3", inst_addr, 32'hFFFF_FFFC);
            4: begin check("l_ia4", inst_addr, 32'h0); check("l_inst4", inst, 32'hA000_0000); end
            5, 6, 7, 8: check("l_hold_ia", inst_addr, 32'h4);
            9: check("l_ia9", inst_addr, 32'h8);
            10: check("l_jreq10", {31'b0, req}, 32'h0);
            11: begin check("l_jaddr11", addr, 32'h100); check("l_jvalid11", {31'b0, valid}, 32'h0); end
            12: check("l_jvalid12", {31'b0, valid}, 32'h0);
            13: begin check("l_jia13", inst_addr, 32'h100); check("l_jinst13", inst, 32'hA000_0100); end
            16: check("l_jhreq16", {31'b0, req}, 32'h0);
            17, 18: check("l_jhvalid", {31'b0, valid}, 32'h0);
            19: check("l_jhia19", inst_addr, 32'h200);
            22, 23, 24, 25: check("l_stall_addr", addr, 32'h214);
            24: ;
            27: check("l_ia27", inst_addr, 32'h214);
            30: begin check("l_rst_valid", {31'b0, valid}, 32'h0); check("l_rst_inst", inst, NOP); end
            31: check("l_raddr31", addr, 32'hFFFF_FFF8);
            32: check("l_rvalid32", {31'b0, valid}, 32'h0);
            33: check("l_ria33", inst_addr, 32'hFFFF_FFF8);
            default: ;
        endcase
    endtask

    initial begin
        @(posedge clk); #1;
        model_on = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 75; c++) begin
            drive(c);
            cyc = c;
            @(negedge clk);
            literal(c);
            @(posedge clk); #1;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
